// File: rtl/eh2_lsu_bus_clken_gen.sv
// LSU bus clock-enable generator and bus-synchronised force-halt stretcher.
// Optional ratio counter under RV_LSU_BUS_RATIO_EN; otherwise a fixed 1:1 bus.

module eh2_lsu_halt_stretch (
  input  logic clk,
  input  logic rst,
  input  logic bus_en,
  input  logic halt,
  output logic halt_bus
);
  logic stretch_q;

  // Hold a short halt pulse until a bus edge has had a chance to see it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         stretch_q <= 1'b0;
    else if (halt)   stretch_q <= 1'b1;
    else if (bus_en) stretch_q <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         halt_bus <= 1'b0;
    else if (bus_en) halt_bus <= stretch_q | halt;
  end
endmodule

module eh2_lsu_bus_clken_gen #(
  parameter int NUM_THREADS = 2,
  parameter int RATIO_W     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RATIO_W-1:0]     bus_clk_ratio,
  input  logic [NUM_THREADS-1:0] dec_tlu_force_halt,
  input  logic                   scan_mode,
  output logic                   lsu_bus_clk_en,
  output logic                   lsu_bus_clk_en_q,
  output logic [NUM_THREADS-1:0] dec_tlu_force_halt_bus
);
  logic en_q;

`ifdef RV_LSU_BUS_RATIO_EN
  logic [RATIO_W-1:0] cnt;

  // Ratio is sampled only at reload, so a running period is never cut short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      en_q <= 1'b0;
    end else if (cnt == '0) begin
      cnt  <= bus_clk_ratio;
      en_q <= 1'b1;
    end else begin
      cnt  <= cnt - 1'b1;
      en_q <= 1'b0;
    end
  end
`else
  logic unused_ratio;
  assign unused_ratio = ^bus_clk_ratio;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) en_q <= 1'b0;
    else     en_q <= 1'b1;
  end
`endif

  assign lsu_bus_clk_en = en_q | scan_mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lsu_bus_clk_en_q <= 1'b0;
    else     lsu_bus_clk_en_q <= lsu_bus_clk_en;
  end

  for (genvar i = 0; i < NUM_THREADS; i++) begin : g_thr
    eh2_lsu_halt_stretch u_stretch (
      .clk      (clk),
      .rst      (rst),
      .bus_en   (lsu_bus_clk_en),
      .halt     (dec_tlu_force_halt[i]),
      .halt_bus (dec_tlu_force_halt_bus[i])
    );
  end
endmodule

// File: tb/tb_eh2_lsu_bus_clken_gen.sv
// Scoreboard bench for eh2_lsu_bus_clken_gen; ratio tests run when RV_LSU_BUS_RATIO_EN is defined.
module tb_eh2_lsu_bus_clken_gen;
  localparam int NT = 2;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [RW-1:0] bus_clk_ratio = '0;
  logic [NT-1:0] dec_tlu_force_halt = '0;
  logic          scan_mode = 1'b0;
  logic          lsu_bus_clk_en;
  logic          lsu_bus_clk_en_q;
  logic [NT-1:0] dec_tlu_force_halt_bus;

  eh2_lsu_bus_clken_gen #(.NUM_THREADS(NT), .RATIO_W(RW)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .bus_clk_ratio          (bus_clk_ratio),
    .dec_tlu_force_halt     (dec_tlu_force_halt),
    .scan_mode              (scan_mode),
    .lsu_bus_clk_en         (lsu_bus_clk_en),
    .lsu_bus_clk_en_q       (lsu_bus_clk_en_q),
    .dec_tlu_force_halt_bus (dec_tlu_force_halt_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           chk;
    logic [NT+1:0] exp;   // {en, en_q, halt_bus}
    int           tag;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;
  bit   finished = 1'b0;

  // Monitor: one expected entry per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [NT+1:0] got;
      e   = q.pop_front();
      got = {lsu_bus_clk_en, lsu_bus_clk_en_q, dec_tlu_force_halt_bus};
      if (e.chk) begin
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL test%0d cyc%0d {en,en_q,halt_bus} got %b want %b", e.tag, e.cyc, got, e.exp);
        end
      end
    end
    if (done && !finished) begin
      if (q.size() != 0) begin
        errors++;
        $display("FAIL drain: %0d entries left, want 0", q.size());
      end
      finished = 1'b1;
    end
  end

  task automatic step(input logic r, input logic [RW-1:0] ratio, input logic [NT-1:0] h,
                      input logic s, input bit chk, input logic e, input logic eq,
                      input logic [NT-1:0] b, input int tag, input int cyc);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; bus_clk_ratio = ratio; dec_tlu_force_halt = h; scan_mode = s;
    x.chk = chk; x.exp = {e, eq, b}; x.tag = tag; x.cyc = cyc;
    q.push_back(x);
  endtask

  task automatic hold_reset(input int tag);
    for (int k = 0; k < 2; k++) step(1'b1, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0, tag, -1 - k);
  endtask

  initial begin
    // Reset state, and scan_mode forcing the enable while the flops are held.
    hold_reset(1);
    step(1'b1, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0, '0, 2, -1);
    step(1'b1, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 2, -2);

`ifdef RV_LSU_BUS_RATIO_EN
    // Ratio 0: constant enable from cycle 1.
    for (int c = 0; c < 6; c++)
      step(1'b0, 3'd0, '0, 1'b0, 1'b1, c >= 1, c >= 2, '0, 10, c);

    // Ratio 3 with a scan_mode blip at cycle 3 (counter unaffected).
    hold_reset(11);
    for (int c = 0; c < 15; c++)
      step(1'b0, 3'd3, '0, c == 3, 1'b1, (c % 4 == 1) || c == 3,
           (c % 4 == 2) || c == 4, '0, 11, c);

    // Ratio 3 -> 1 at cycle 3: pulses 1,5,7,9.
    hold_reset(12);
    for (int c = 0; c < 11; c++)
      step(1'b0, (c < 3) ? 3'd3 : 3'd1, '0, 1'b0, 1'b1,
           c == 1 || c == 5 || c == 7 || c == 9,
           c == 2 || c == 6 || c == 8 || c == 10, '0, 12, c);

    // Single-cycle halt on thread 1 at cycle 2: held for one bus period.
    hold_reset(13);
    for (int c = 0; c < 13; c++)
      step(1'b0, 3'd3, (c == 2) ? 2'b10 : 2'b00, 1'b0, 1'b1, c % 4 == 1, c % 4 == 2,
           (c >= 6 && c <= 9) ? 2'b10 : 2'b00, 13, c);

    // Halt pulse on an enable cycle: two bus periods.
    hold_reset(14);
    for (int c = 0; c < 16; c++)
      step(1'b0, 3'd3, (c == 5) ? 2'b10 : 2'b00, 1'b0, 1'b1, c % 4 == 1, c % 4 == 2,
           (c >= 6 && c <= 13) ? 2'b10 : 2'b00, 14, c);

    // Reset mid-period with a halt pending; schedule restarts, halt discarded.
    hold_reset(15);
    for (int c = 0; c < 7; c++)
      step(1'b0, 3'd3, (c == 6) ? 2'b01 : 2'b00, 1'b0, 1'b1, c % 4 == 1, c % 4 == 2, '0, 15, c);
    step(1'b1, 3'd3, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 15, 7);
    step(1'b1, 3'd3, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 15, 8);
    for (int c = 0; c < 7; c++)
      step(1'b0, 3'd3, '0, 1'b0, 1'b1, c % 4 == 1, c % 4 == 2, '0, 16, c);
`else
    // Fixed 1:1 bus, ratio ignored. Thread 0 pulse at 4, thread 1 held 10..12.
    // Cycle 6 is left unchecked for thread 0 (the stretch bit recaptures it there).
    for (int c = 0; c < 17; c++) begin
      logic [NT-1:0] h, b;
      h = {c >= 10 && c <= 12, c == 4 || c == 16};
      b = {c >= 11 && c <= 14, c == 5};
      step(1'b0, 3'd5, h, 1'b0, c != 6, c >= 1, c >= 2, b, 20, c);
    end
    // Reset with thread 0 halt pending from cycle 16: everything clears at once.
    step(1'b1, 3'd5, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 21, 17);
    step(1'b1, 3'd5, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 21, 18);
    for (int c = 0; c < 4; c++)
      step(1'b0, 3'd5, '0, 1'b0, 1'b1, c >= 1, c >= 2, '0, 22, c);
`endif

    @(posedge clk);
    #1 done = 1'b1;
    for (int k = 0; k < 10 && !finished; k++) @(posedge clk);
    if (!finished) begin
      $display("FAIL monitor: no drain within 10 cycles");
      $fatal(1, "monitor stalled");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
